rvv_backend_alu2rob_buffer: RTL and testbench

- Receiving end of the ALU to ROB result interface: collects per-cycle `result_valid`/`ALU2ROB_t` pulses from NUM_ALU ALU units and drains them to the ROB write-back port over a valid/ready handshake.
- ALU units have no backpressure, so this block returns an `alu_ready` credit signal. The ALU reservation station stops issuing while it is low.
- Sits between the ALU units and the ROB inside rvv_backend.

---
 rtl/rvv_backend_alu2rob_buffer.sv | 156 +++++++++++++++
 tb/tb_rvv_backend_alu2rob_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_alu2rob_buffer.sv
// ALU-to-ROB result buffer: compacts per-port ALU result pulses into a circular FIFO
// and drains it to the ROB. Optional same-cycle bypass with RVV_ALU2ROB_BYPASS_EN.

package rvv_alu2rob_pkg;
    typedef struct packed {
        logic [4:0]   rob_entry;
        logic [127:0] w_data;
        logic [15:0]  w_valid;
        logic         vxsat;
        logic         ignore_vta;
        logic         ignore_vma;
    } ALU2ROB_t;
endpackage

// One push port: accepted only if its compacted slot fits in the free space.
module rvv_alu2rob_port_slot #(
    parameter int CW = 3
) (
    input  logic          valid,
    input  logic [CW-1:0] offset,
    input  logic [CW-1:0] free,
    output logic          accept,
    output logic          drop
);
    assign accept = valid && (offset < free);
    assign drop   = valid && !accept;
endmodule

module rvv_backend_alu2rob_buffer
    import rvv_alu2rob_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_ALU = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_ALU-1:0]        result_valid,
    input  ALU2ROB_t [NUM_ALU-1:0]    result,
    output logic                      alu_ready,
    output logic                      rob_valid,
    output ALU2ROB_t                  rob_data,
    input  logic                      rob_ready,
    output logic                      overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    ALU2ROB_t      entry_q [DEPTH];
    ALU2ROB_t      entry_d [DEPTH];

    logic [CW-1:0]               free;
    logic [CW-1:0]               n_push;
    logic [NUM_ALU-1:0]          slot_vld, accept, drop;
    logic [NUM_ALU-1:0][CW-1:0]  offset;
    logic                        byp_take;
    logic                        pop;

    assign free = CW'(DEPTH) - count_q;

`ifdef RVV_ALU2ROB_BYPASS_EN
    // Idle buffer and ROB ready: port 0 goes straight through and never takes a slot.
    assign byp_take = (count_q == '0) && result_valid[0] && rob_ready;
`else
    assign byp_take = 1'b0;
`endif

    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        slot_vld = result_valid;
        slot_vld[0] = result_valid[0] & ~byp_take;
        for (int i = 0; i < NUM_ALU; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(slot_vld[i]);
        end
    end

    for (genvar g = 0; g < NUM_ALU; g++) begin : g_port
        rvv_alu2rob_port_slot #(.CW(CW)) u_slot (
            .valid  (slot_vld[g]),
            .offset (offset[g]),
            .free   (free),
            .accept (accept[g]),
            .drop   (drop[g])
        );
    end

    // Free space comes from the registered count only; a same-cycle pop does not help.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_ALU; i++)
            n_push = n_push + CW'(accept[i]);
        pop     = (count_q != '0) && rob_ready;
        wptr_d  = wptr_q + n_push[PW-1:0];
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + n_push - CW'(pop);
        ovf_d   = ovf_q | (|drop);
    end

    always_comb begin
        logic [PW-1:0] widx;
        widx    = '0;
        entry_d = entry_q;
        for (int i = 0; i < NUM_ALU; i++) begin
            widx = wptr_q + offset[i][PW-1:0];
            if (accept[i])
                entry_d[widx] = result[i];
        end
    end

    always_comb begin
        alu_ready    = (free >= CW'(NUM_ALU));
        rob_valid    = (count_q != '0);
        rob_data     = rob_valid ? entry_q[rptr_q] : '0;
        overflow_err = ovf_q;
`ifdef RVV_ALU2ROB_BYPASS_EN
        if ((count_q == '0) && result_valid[0]) begin
            rob_valid = 1'b1;
            rob_data  = result[0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

`ifdef ASSERT_ON
    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|result_valid) && !alu_ready))
                else $error("alu2rob: push while alu_ready low");
            assert (count_q <= CW'(DEPTH))
                else $error("alu2rob: count above DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_rvv_backend_alu2rob_buffer.sv
// Scoreboard bench for rvv_backend_alu2rob_buffer (default build, no bypass).
module tb_rvv_backend_alu2rob_buffer;
    import rvv_alu2rob_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         result_valid = '0;
    ALU2ROB_t [1:0]     result = '0;
    logic               alu_ready, rob_valid, overflow_err;
    logic               rob_ready = 1'b0;
    ALU2ROB_t           rob_data;

    ALU2ROB_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvv_backend_alu2rob_buffer #(.DEPTH(4), .NUM_ALU(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .alu_ready    (alu_ready),
        .rob_valid    (rob_valid),
        .rob_data     (rob_data),
        .rob_ready    (rob_ready),
        .overflow_err (overflow_err)
    );

    function automatic ALU2ROB_t mk(input int e);
        ALU2ROB_t p;
        p            = '0;
        p.rob_entry  = 5'(e);
        p.w_data     = {$urandom, $urandom, $urandom, $urandom};
        p.w_valid    = 16'($urandom);
        p.vxsat      = 1'($urandom);
        p.ignore_vta = 1'($urandom);
        p.ignore_vma = 1'($urandom);
        return p;
    endfunction

    // Drive one cycle of ALU results; nothing is queued here.
    task automatic drive(input logic [1:0] v, input int e0, input int e1);
        result_valid = v;
        result[0]    = mk(e0);
        result[1]    = mk(e1);
    endtask

    task automatic idle();
        result_valid = '0;
        result       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rob_valid !== 1'b0 || alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: rob_valid=%b alu_ready=%b, want 0/1", rob_valid, alu_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rob_valid !== 1'b0 || alu_ready !== 1'b1 || overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: rob_valid=%b alu_ready=%b ovf=%b, want 0/1/0",
                     rob_valid, alu_ready, overflow_err);
        end
        n_cmp++;
        if (rob_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: rob_data.rob_entry=%0d w_data=%h, want 0",
                     rob_data.rob_entry, rob_data.w_data);
        end
    endtask

    task automatic test_single();
        rob_ready = 1'b1;
        drive(2'b01, 3, 0);
        exp_q.push_back(result[0]);
        @(negedge clk);
        idle();
        n_cmp++;
        if (rob_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: rob_valid=%b, want 1", rob_valid);
        end else if (rob_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL single_data: rob_entry=%0d, want %0d", rob_data.rob_entry, exp_q[0].rob_entry);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        n_cmp++;
        if (rob_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_empty: rob_valid=%b, want 0", rob_valid);
        end
        rob_ready = 1'b0;
    endtask

    task automatic test_dual_order();
        rob_ready = 1'b0;
        drive(2'b11, 5, 6);
        exp_q.push_back(result[0]);
        exp_q.push_back(result[1]);
        @(negedge clk);
        idle();
        repeat (3) begin
            n_cmp++;
            if (rob_valid !== 1'b1 || rob_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL dual_stall: rob_valid=%b rob_entry=%0d, want 1/%0d",
                         rob_valid, rob_data.rob_entry, exp_q[0].rob_entry);
            end
            @(negedge clk);
        end
        rob_ready = 1'b1;
        repeat (2) begin
            n_cmp++;
            if (rob_valid !== 1'b1 || rob_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL dual_order: rob_valid=%b rob_entry=%0d, want 1/%0d",
                         rob_valid, rob_data.rob_entry, exp_q[0].rob_entry);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        n_cmp++;
        if (rob_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dual_empty: rob_valid=%b, want 0", rob_valid);
        end
        rob_ready = 1'b0;
    endtask

    task automatic test_fill_credit();
        rob_ready = 1'b0;
        drive(2'b11, 10, 11);
        exp_q.push_back(result[0]);
        exp_q.push_back(result[1]);
        @(negedge clk);
        drive(2'b11, 12, 13);
        exp_q.push_back(result[0]);
        exp_q.push_back(result[1]);
        @(negedge clk);
        idle();
        n_cmp++;
        if (alu_ready !== 1'b0 || rob_valid !== 1'b1 || rob_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL fill_full: alu_ready=%b rob_valid=%b rob_entry=%0d, want 0/1/%0d",
                     alu_ready, rob_valid, rob_data.rob_entry, exp_q[0].rob_entry);
        end
        rob_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        rob_ready = 1'b0;
        n_cmp++;
        if (alu_ready !== 1'b0 || rob_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL fill_one_free: alu_ready=%b rob_entry=%0d, want 0/%0d",
                     alu_ready, rob_data.rob_entry, exp_q[0].rob_entry);
        end
        rob_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        rob_ready = 1'b0;
        n_cmp++;
        if (alu_ready !== 1'b1 || rob_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL fill_two_free: alu_ready=%b rob_entry=%0d, want 1/%0d",
                     alu_ready, rob_data.rob_entry, exp_q[0].rob_entry);
        end
        rob_ready = 1'b1;
        for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
            if (rob_valid === 1'b1) begin
                n_cmp++;
                if (rob_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL fill_drain: rob_entry=%0d, want %0d", rob_data.rob_entry, exp_q[0].rob_entry);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0 || rob_valid !== 1'b0 || overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL fill_end: left=%0d rob_valid=%b ovf=%b, want 0/0/0",
                     exp_q.size(), rob_valid, overflow_err);
        end
        rob_ready = 1'b0;
    endtask

    task automatic test_overflow();
        rob_ready = 1'b0;
        drive(2'b11, 20, 21);
        exp_q.push_back(result[0]);
        exp_q.push_back(result[1]);
        @(negedge clk);
        drive(2'b01, 22, 0);
        exp_q.push_back(result[0]);
        @(negedge clk);
        n_cmp++;
        if (alu_ready !== 1'b0 || overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pre: alu_ready=%b ovf=%b, want 0/0", alu_ready, overflow_err);
        end
        drive(2'b11, 23, 24);
        exp_q.push_back(result[0]);
        @(negedge clk);
        idle();
        n_cmp++;
        if (overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: ovf=%b, want 1", overflow_err);
        end
        rob_ready = 1'b1;
        for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
            if (rob_valid === 1'b1) begin
                n_cmp++;
                if (rob_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL ovf_drain: rob_entry=%0d, want %0d", rob_data.rob_entry, exp_q[0].rob_entry);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || rob_valid !== 1'b0 || overflow_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: left=%0d rob_valid=%b ovf=%b, want 0/0/1",
                     exp_q.size(), rob_valid, overflow_err);
        end
        // Buffered entry plus an in-flight push during reset must both vanish.
        rob_ready = 1'b0;
        drive(2'b01, 30, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b01, 31, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_cmp++;
        if (rob_valid !== 1'b0 || overflow_err !== 1'b0 || alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_reset: rob_valid=%b ovf=%b alu_ready=%b, want 0/0/1",
                     rob_valid, overflow_err, alu_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rob_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_discard: rob_valid=%b, want 0", rob_valid);
        end
    endtask

    task automatic test_wrap_stream();
        int got;
        got = 0;
        rob_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                n_cmp++;
                if (rob_valid !== 1'b1 || exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wrap_latency: k=%0d rob_valid=%b, want 1", k, rob_valid);
                end
            end
            if (rob_valid === 1'b1 && exp_q.size() > 0) begin
                n_cmp++;
                if (rob_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL wrap_order: rob_entry=%0d, want %0d", rob_data.rob_entry, exp_q[0].rob_entry);
                end
                void'(exp_q.pop_front());
                got++;
            end
            n_cmp++;
            if (alu_ready !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_credit: k=%0d alu_ready=%b, want 1", k, alu_ready);
            end
            drive(2'b01, k, 0);
            exp_q.push_back(result[0]);
            @(negedge clk);
        end
        idle();
        for (int c = 0; c < 16 && exp_q.size() > 0; c++) begin
            if (rob_valid === 1'b1) begin
                n_cmp++;
                if (rob_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL wrap_order: rob_entry=%0d, want %0d", rob_data.rob_entry, exp_q[0].rob_entry);
                end
                void'(exp_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (got != 10 || rob_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_total: received=%0d rob_valid=%b, want 10/0", got, rob_valid);
        end
        rob_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_fill_credit();
        test_overflow();
        test_wrap_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
